seq_detect_prog: RTL and testbench

//  Programmable serial pattern detector; replaces the fixed one-pattern Moore detectors.

---
 rtl/seq_detect_prog.sv | 80 ++++++++
 tb/tb_seq_detect_prog.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: compares the last LEN sampled bits against a
// run-time pattern/care-mask pair, with overlapping or restarting matching and a saturating count.
module seq_detect_prog #(
  parameter int             LEN      = 8,
  parameter logic [LEN-1:0] PAT_RST  = LEN'(8'h55),
  parameter logic [LEN-1:0] MASK_RST = {LEN{1'b1}},
  parameter int             CNT_W    = 8,
  localparam int            FILL_W   = $clog2(LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              din_i,
  input  logic              overlap_i,
  input  logic              load_i,
  input  logic [LEN-1:0]    pat_i,
  input  logic [LEN-1:0]    mask_i,
  input  logic              clr_cnt_i,
  output logic              flag_o,
  output logic [CNT_W-1:0]  match_cnt_o,
  output logic [FILL_W-1:0] fill_o
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [LEN-1:0]    hist_q, hist_d;
  logic [LEN-1:0]    pat_q;
  logic [LEN-1:0]    mask_q;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              flag_q;
  logic              match;

  // Match is judged on the window as it will look after this edge's sample.
  always_comb begin
    hist_d = {hist_q[LEN-2:0], din_i};
    fill_d = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    match  = en_i && !load_i && (fill_d == FILL_FULL) &&
             (((hist_d ^ pat_q) & mask_q) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      flag_q <= 1'b0;
      pat_q  <= PAT_RST;
      mask_q <= MASK_RST;
    end else if (load_i) begin
      pat_q  <= pat_i;
      mask_q <= mask_i;
      hist_q <= '0;
      fill_q <= '0;
      flag_q <= 1'b0;
    end else if (en_i) begin
      hist_q <= hist_d;
      // Non-overlapping mode restarts the window so the next match needs LEN fresh bits.
      fill_q <= (match && !overlap_i) ? '0 : fill_d;
      flag_q <= match;
    end else begin
      flag_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_cnt_i) begin
      cnt_q <= match ? CNT_W'(1) : '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign flag_o      = flag_q;
  assign match_cnt_o = cnt_q;
  assign fill_o      = fill_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed table/sequence checks plus randomized traffic
// compared against a queue-based window model.
module tb_seq_detect_prog;
  localparam int LEN = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, din, ov, ld, clr;
  logic [7:0] pin, mk;
  logic       flag, flag2;
  logic [7:0] cnt;
  logic [1:0] cnt2;
  logic [3:0] fill, fill2;

  always #5 clk = ~clk;

  seq_detect_prog u_dut (
    .clk(clk), .rst(rst), .en_i(en), .din_i(din), .overlap_i(ov), .load_i(ld),
    .pat_i(pin), .mask_i(mk), .clr_cnt_i(clr),
    .flag_o(flag), .match_cnt_o(cnt), .fill_o(fill)
  );

  seq_detect_prog #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en_i(en), .din_i(din), .overlap_i(ov), .load_i(ld),
    .pat_i(pin), .mask_i(mk), .clr_cnt_i(clr),
    .flag_o(flag2), .match_cnt_o(cnt2), .fill_o(fill2)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the window is a queue of bits received since the last restart.
  bit         win[$];
  logic [7:0] mpat, mmask;
  int         mcnt, mcnt2;
  bit         mflag;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_match();
    if (win.size() != LEN) return 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (mmask[LEN-1-i] && (win[i] != mpat[LEN-1-i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    win.delete();
    mpat  = 8'h55;
    mmask = 8'hFF;
    mcnt  = 0;
    mcnt2 = 0;
    mflag = 1'b0;
  endtask

  task automatic check_model();
    chk("flag", int'(flag), int'(mflag));
    chk("fill", int'(fill), win.size());
    chk("cnt", int'(cnt), mcnt);
    chk("flag_sat", int'(flag2), int'(mflag));
    chk("cnt_sat", int'(cnt2), mcnt2);
  endtask

  task automatic cycle(input bit e, input bit d, input bit o, input bit l, input bit c,
                       input logic [7:0] p, input logic [7:0] m);
    bit hit;
    en = e; din = d; ov = o; ld = l; clr = c; pin = p; mk = m;
    @(posedge clk);
    #1;
    hit = 1'b0;
    if (l) begin
      mpat = p; mmask = m; win.delete(); mflag = 1'b0;
    end else if (e) begin
      win.push_back(d);
      if (win.size() > LEN) void'(win.pop_front());
      hit   = model_match();
      mflag = hit;
      if (hit && !o) win.delete();
    end else begin
      mflag = 1'b0;
    end
    if (c) begin
      mcnt  = hit ? 1 : 0;
      mcnt2 = hit ? 1 : 0;
    end else if (hit) begin
      if (mcnt < 255) mcnt++;
      if (mcnt2 < 3) mcnt2++;
    end
    check_model();
  endtask

  task automatic bitin(input bit d, input bit o);
    cycle(1'b1, d, o, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    en = 0; din = 0; ov = 0; ld = 0; clr = 0; pin = 0; mk = 0;
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check_model();
    rst = 1'b0;
  endtask

  typedef struct {
    bit din;
    bit exp_flag;
    int exp_fill;
    int exp_cnt;
  } vec_t;

  vec_t t1[10];

  initial begin
    t1[0] = '{0, 0, 1, 0};
    t1[1] = '{1, 0, 2, 0};
    t1[2] = '{0, 0, 3, 0};
    t1[3] = '{1, 0, 4, 0};
    t1[4] = '{0, 0, 5, 0};
    t1[5] = '{1, 0, 6, 0};
    t1[6] = '{0, 0, 7, 0};
    t1[7] = '{1, 1, 8, 1};
    t1[8] = '{0, 0, 8, 1};
    t1[9] = '{1, 1, 8, 2};

    // T1: defaults, overlapping, table-driven
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bitin(t1[i].din, 1'b1);
      chk("t1_flag", int'(flag), int'(t1[i].exp_flag));
      chk("t1_fill", int'(fill), t1[i].exp_fill);
      chk("t1_cnt", int'(cnt), t1[i].exp_cnt);
    end

    // T2: non-overlapping, 16 bits
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      bitin(bit'((i - 1) % 2), 1'b0);
      chk("t2_flag", int'(flag), (i == 8 || i == 16) ? 1 : 0);
    end
    chk("t2_cnt", int'(cnt), 2);
    chk("t2_fill", int'(fill), 0);

    // T3: partial-care pattern
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'hF0, 8'hF0);
    chk("t3_fill_load", int'(fill), 0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] s;
      s = 8'b1111_1010;
      bitin(s[i], 1'b1);
      chk("t3_hit", int'(flag), (i == 0) ? 1 : 0);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hF0, 8'hF0);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] s;
      s = 8'b1110_0000;
      bitin(s[i], 1'b1);
      chk("t3_miss", int'(flag), 0);
    end

    // T4: load mid-window discards the partial window and its din
    do_reset();
    for (int i = 0; i < 7; i++) bitin(bit'(i % 2), 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h55, 8'hFF);
    chk("t4_fill0", int'(fill), 0);
    chk("t4_flag0", int'(flag), 0);
    bitin(1'b1, 1'b1);
    chk("t4_fill1", int'(fill), 1);
    chk("t4_flag1", int'(flag), 0);

    // T5: 2-bit counter saturates; clear coinciding with a match leaves 1
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      bitin(bit'((i - 1) % 2), 1'b1);
      if (i == 8)  chk("t5_c1", int'(cnt2), 1);
      if (i == 10) chk("t5_c2", int'(cnt2), 2);
      if (i == 12) chk("t5_c3", int'(cnt2), 3);
      if (i == 14) chk("t5_sat", int'(cnt2), 3);
    end
    bitin(1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("t5_clr_hit", int'(cnt2), 1);
    chk("t5_clr_hit8", int'(cnt), 1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("t5_clr", int'(cnt), 0);

    // T6: enable gaps hold state; async reset mid-stream restores defaults
    do_reset();
    for (int i = 0; i < 4; i++) bitin(bit'(i % 2), 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("t6_gap_fill", int'(fill), 4);
      chk("t6_gap_flag", int'(flag), 0);
    end
    for (int i = 0; i < 4; i++) begin
      bitin(bit'(i % 2), 1'b1);
      chk("t6_flag", int'(flag), (i == 3) ? 1 : 0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("t6_flag_drop", int'(flag), 0);
    chk("t6_fill_hold", int'(fill), 8);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 8'hFF);
    for (int i = 0; i < 5; i++) bitin(bit'(i % 2), 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_fill", int'(fill), 0);
    chk("t6_rst_flag", int'(flag), 0);
    chk("t6_rst_cnt", int'(cnt), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bitin(bit'(i % 2), 1'b1);
      chk("t6_pat_rst", int'(flag), (i == 7) ? 1 : 0);
    end

    // Randomized traffic against the model, including don't-care-all masks
    do_reset();
    for (int n = 0; n < 2500; n++) begin
      bit         e, d, o, l, c;
      logic [7:0] p, m;
      e = ($urandom_range(0, 3) != 0);
      d = 1'(($urandom() >> 3) & 1);
      o = ($urandom_range(0, 7) != 0) ? ov : ~ov;
      l = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 3))
        0:       m = 8'h00;
        1:       m = 8'($urandom()) & 8'h0F;
        2:       m = 8'hFF;
        default: m = 8'($urandom());
      endcase
      p = 8'($urandom());
      cycle(e, d, o, l, c, p, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
